// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate-decode stage.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_J    = 3'd4,
    IMM_U    = 3'd5,
    IMM_SH   = 3'd6,
    IMM_V    = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_OPV     = 7'b1010111;

  localparam logic [2:0] FUNCT3_OPIVI = 3'b011;
  localparam logic [2:0] FUNCT3_SLLI  = 3'b001;
  localparam logic [2:0] FUNCT3_SRXI  = 3'b101;

  // Shift-immediate encodings share the OP-IMM opcodes; funct3 tells them apart.
  function automatic logic is_shift_f3(input logic [2:0] f3);
    return (f3 == FUNCT3_SLLI) || (f3 == FUNCT3_SRXI);
  endfunction

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational immediate classifier/extender plus PC-relative target adder.
module imm_decode_comb
  import imm_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit VEC_EN = 1'b1
) (
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] imm_o,
  output imm_fmt_e        fmt_o,
  output logic [XLEN-1:0] target_o
);

  // Sign-extend the low w bits of v to XLEN (w in 1..32).
  function automatic logic [XLEN-1:0] sext(input logic [31:0] v, input int w);
    logic signed [31:0] s;
    s = $signed(v << (32 - w)) >>> (32 - w);
    return XLEN'(s);
  endfunction

  logic [6:0] opc;
  logic [2:0] f3;
  logic       is_sh;

  assign opc   = instr_i[6:0];
  assign f3    = instr_i[14:12];
  assign is_sh = is_shift_f3(f3);

  always_comb begin
    fmt_o = IMM_NONE;
    imm_o = '0;
    case (opc)
      OPC_LOAD, OPC_JALR: begin
        fmt_o = IMM_I;
        imm_o = sext({20'b0, instr_i[31:20]}, 12);
      end
      OPC_OPIMM: begin
        if (is_sh) begin
          fmt_o = IMM_SH;
          imm_o = (XLEN == 64) ? XLEN'(instr_i[25:20]) : XLEN'(instr_i[24:20]);
        end else begin
          fmt_o = IMM_I;
          imm_o = sext({20'b0, instr_i[31:20]}, 12);
        end
      end
      OPC_OPIMM32: begin
        // Word ops only exist on RV64; on RV32 this opcode is unused.
        if (XLEN == 64) begin
          if (is_sh) begin
            fmt_o = IMM_SH;
            imm_o = XLEN'(instr_i[24:20]);
          end else begin
            fmt_o = IMM_I;
            imm_o = sext({20'b0, instr_i[31:20]}, 12);
          end
        end
      end
      OPC_STORE: begin
        fmt_o = IMM_S;
        imm_o = sext({20'b0, instr_i[31:25], instr_i[11:7]}, 12);
      end
      OPC_BRANCH: begin
        fmt_o = IMM_B;
        imm_o = sext({19'b0, instr_i[31], instr_i[7], instr_i[30:25],
                      instr_i[11:8], 1'b0}, 13);
      end
      OPC_JAL: begin
        fmt_o = IMM_J;
        imm_o = sext({11'b0, instr_i[31], instr_i[19:12], instr_i[20],
                      instr_i[30:21], 1'b0}, 21);
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt_o = IMM_U;
        imm_o = sext({instr_i[31:12], 12'b0}, 32);
      end
      OPC_OPV: begin
        if (VEC_EN && (f3 == FUNCT3_OPIVI)) begin
          fmt_o = IMM_V;
          imm_o = sext({27'b0, instr_i[19:15]}, 5);
        end
      end
      default: ;
    endcase
  end

  assign target_o = pc_i + imm_o;

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage: decode on the input side, then a
// two-entry skid buffer (output reg O, skid reg K) decoupling both handshakes.
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit VEC_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_fmt_e        fmt;
    logic [XLEN-1:0] target;
  } ent_t;

  localparam ent_t ENT_RST = '{imm: '0, fmt: IMM_NONE, target: '0};

  logic [XLEN-1:0] dec_imm, dec_target;
  imm_fmt_e        dec_fmt;
  ent_t            dec;

  ent_t o_q, o_d, k_q, k_d;
  logic o_vld_q, o_vld_d;
  logic k_vld_q, k_vld_d;
  logic rdy_q, rdy_d;
  logic acc, drn;

  imm_decode_comb #(
    .XLEN   (XLEN),
    .VEC_EN (VEC_EN)
  ) u_dec (
    .instr_i  (in_instr),
    .pc_i     (in_pc),
    .imm_o    (dec_imm),
    .fmt_o    (dec_fmt),
    .target_o (dec_target)
  );

  always_comb begin
    dec = '{imm: dec_imm, fmt: dec_fmt, target: dec_target};
  end

  assign acc = in_valid && rdy_q;
  assign drn = o_vld_q && out_ready;

  always_comb begin
    o_d     = o_q;
    o_vld_d = o_vld_q;
    k_d     = k_q;
    k_vld_d = k_vld_q;
    if (drn) begin
      if (k_vld_q) begin
        o_d     = k_q;
        o_vld_d = 1'b1;
        k_vld_d = 1'b0;
      end else begin
        o_vld_d = 1'b0;
      end
    end
    // in_ready is low whenever K is full, so accept+drain never collides with K->O.
    if (acc) begin
      if (!o_vld_q || drn) begin
        o_d     = dec;
        o_vld_d = 1'b1;
      end else begin
        k_d     = dec;
        k_vld_d = 1'b1;
      end
    end
    rdy_d = !k_vld_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q     <= ENT_RST;
      k_q     <= ENT_RST;
      o_vld_q <= 1'b0;
      k_vld_q <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      o_q     <= o_d;
      k_q     <= k_d;
      o_vld_q <= o_vld_d;
      k_vld_q <= k_vld_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready   = rdy_q;
  assign out_valid  = o_vld_q;
  assign out_imm    = o_q.imm;
  assign out_fmt    = o_q.fmt;
  assign out_target = o_q.target;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: three configurations driven in lockstep, checked
// against a queue-based FIFO model and an arithmetic immediate reference.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        out_ready;

  logic        vld32, rdy32, vld64, rdy64, vldnv, rdynv;
  logic [31:0] imm32, tg32, immnv, tgnv;
  logic [63:0] imm64, tg64;
  logic [2:0]  fmt32, fmt64, fmtnv;

  int nvec = 0;
  int nmis = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic [31:0] ins;
    logic [63:0] pc;
  } item_t;
  item_t q[$];

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .VEC_EN(1'b1)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(vld32),
    .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32), .out_target(tg32));

  imm_decode_stage #(.XLEN(64), .VEC_EN(1'b1)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(vld64),
    .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64), .out_target(tg64));

  imm_decode_stage #(.XLEN(32), .VEC_EN(1'b0)) unv (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdynv),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(vldnv),
    .out_ready(out_ready), .out_imm(immnv), .out_fmt(fmtnv), .out_target(tgnv));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Two's-complement interpretation of the low 'bits' bits of val.
  function automatic longint sx(input longint val, input int bits);
    longint half = longint'(1) << (bits - 1);
    return (val >= half) ? val - (longint'(1) << bits) : val;
  endfunction

  function automatic void ref_dec(input logic [31:0] ins, input logic [63:0] pc,
                                  input int xl, input bit ven,
                                  output logic [63:0] imm, output logic [2:0] fmt,
                                  output logic [63:0] tgt);
    longint v = 0;
    logic [63:0] mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    logic [2:0] f3 = ins[14:12];
    bit sh = (f3 == 3'd1) || (f3 == 3'd5);
    fmt = 3'd0;
    case (ins[6:0])
      7'h03, 7'h67: begin fmt = 3'd1; v = sx(longint'(ins[31:20]), 12); end
      7'h13: if (sh) begin
               fmt = 3'd6;
               v = (xl == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
             end else begin
               fmt = 3'd1; v = sx(longint'(ins[31:20]), 12);
             end
      7'h1B: if (xl == 64) begin
               if (sh) begin fmt = 3'd6; v = longint'(ins[24:20]); end
               else begin fmt = 3'd1; v = sx(longint'(ins[31:20]), 12); end
             end
      7'h23: begin fmt = 3'd2; v = sx(longint'({ins[31:25], ins[11:7]}), 12); end
      7'h63: begin
               fmt = 3'd3;
               v = sx(longint'({ins[31], ins[7], ins[30:25], ins[11:8]}), 12) * 2;
             end
      7'h6F: begin
               fmt = 3'd4;
               v = sx(longint'({ins[31], ins[19:12], ins[20], ins[30:21]}), 20) * 2;
             end
      7'h37, 7'h17: begin fmt = 3'd5; v = sx(longint'(ins[31:12]), 20) * 4096; end
      7'h57: if (ven && f3 == 3'd3) begin fmt = 3'd7; v = sx(longint'(ins[19:15]), 5); end
      default: ;
    endcase
    imm = 64'(v) & mask;
    tgt = ((pc & mask) + 64'(v)) & mask;
  endfunction

  // Every cycle: handshake flags from FIFO occupancy, payload from the head item.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      logic [63:0] ei, et;
      logic [2:0]  ef;
      logic ev, er;
      ev = (q.size() > 0);
      er = (q.size() < 2);
      chk("valid32", 64'(vld32), 64'(ev));
      chk("ready32", 64'(rdy32), 64'(er));
      chk("valid64", 64'(vld64), 64'(ev));
      chk("ready64", 64'(rdy64), 64'(er));
      chk("validnv", 64'(vldnv), 64'(ev));
      chk("readynv", 64'(rdynv), 64'(er));
      if (ev) begin
        ref_dec(q[0].ins, q[0].pc, 32, 1'b1, ei, ef, et);
        chk("imm32", 64'(imm32), ei); chk("fmt32", 64'(fmt32), 64'(ef));
        chk("tgt32", 64'(tg32), et);
        ref_dec(q[0].ins, q[0].pc, 64, 1'b1, ei, ef, et);
        chk("imm64", imm64, ei); chk("fmt64", 64'(fmt64), 64'(ef));
        chk("tgt64", tg64, et);
        ref_dec(q[0].ins, q[0].pc, 32, 1'b0, ei, ef, et);
        chk("immnv", 64'(immnv), ei); chk("fmtnv", 64'(fmtnv), 64'(ef));
        chk("tgtnv", 64'(tgnv), et);
      end
    end
  end

  // One clock of stimulus; model is advanced just after the edge.
  task automatic step(input bit v, input logic [31:0] ins, input logic [63:0] pc, input bit ordy);
    bit acc, drn;
    item_t it;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    acc = v && (q.size() < 2);
    drn = ordy && (q.size() > 0);
    @(posedge clk);
    #1;
    if (drn) void'(q.pop_front());
    if (acc) begin
      it.ins = ins;
      it.pc  = pc;
      q.push_back(it);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst valid32", 64'(vld32), 64'd0);
    chk("rst ready32", 64'(rdy32), 64'd1);
    chk("rst imm32",   64'(imm32), 64'd0);
    chk("rst fmt32",   64'(fmt32), 64'd0);
    chk("rst tgt32",   64'(tg32),  64'd0);
    chk("rst valid64", 64'(vld64), 64'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Decode patterns, streamed one per cycle with out_ready high.
    step(1, 32'hFFF00093, 64'h0, 1);
    chk("addi imm32", 64'(imm32), 64'hFFFF_FFFF);
    chk("addi fmt32", 64'(fmt32), 64'd1);
    chk("addi tgt32", 64'(tg32),  64'hFFFF_FFFF);
    chk("addi imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1, 32'hFE000EE3, 64'h100, 1);
    chk("beq imm32", 64'(imm32), 64'hFFFF_FFFC);
    chk("beq fmt32", 64'(fmt32), 64'd3);
    chk("beq tgt32", 64'(tg32),  64'h0000_00FC);
    step(1, 32'h4030D093, 64'h0, 1);
    chk("srai3 imm32", 64'(imm32), 64'd3);
    chk("srai3 fmt32", 64'(fmt32), 64'd6);
    chk("srai3 imm64", imm64, 64'd3);
    step(1, 32'h43F0D093, 64'h0, 1);
    chk("srai63 imm64", imm64, 64'h3F);
    chk("srai63 imm32", 64'(imm32), 64'h1F);
    step(1, 32'h022EB0D7, 64'h200, 1);
    chk("vi imm32", 64'(imm32), 64'hFFFF_FFFD);
    chk("vi fmt32", 64'(fmt32), 64'd7);
    chk("vi fmtnv", 64'(fmtnv), 64'd0);
    chk("vi immnv", 64'(immnv), 64'd0);
    chk("vi tgtnv", 64'(tgnv),  64'h200);
    step(1, 32'h800000B7, 64'h0, 1);
    chk("lui imm32", 64'(imm32), 64'h8000_0000);
    chk("lui imm64", imm64, 64'hFFFF_FFFF_8000_0000);
    chk("lui fmt64", 64'(fmt64), 64'd5);
    step(1, 32'hFE112C23, 64'h40, 1);
    chk("sw imm32", 64'(imm32), 64'hFFFF_FFF8);
    chk("sw tgt32", 64'(tg32),  64'h38);
    step(1, 32'h0080006F, 64'h1000, 1);
    chk("jal imm32", 64'(imm32), 64'd8);
    chk("jal fmt32", 64'(fmt32), 64'd4);
    chk("jal tgt32", 64'(tg32),  64'h1008);
    step(1, 32'h0010809B, 64'h0, 1);
    chk("addiw fmt32", 64'(fmt32), 64'd0);
    chk("addiw fmt64", 64'(fmt64), 64'd1);
    chk("addiw imm64", imm64, 64'd1);
    step(1, 32'h0030909B, 64'h0, 1);
    chk("slliw fmt64", 64'(fmt64), 64'd6);
    chk("slliw imm64", imm64, 64'd3);
    step(1, 32'h00000033, 64'h44, 1);
    chk("none fmt32", 64'(fmt32), 64'd0);
    chk("none tgt32", 64'(tg32),  64'h44);
    step(0, 32'h0, 64'h0, 1);
    chk("drained valid", 64'(vld32), 64'd0);

    // Backpressure: three items offered with out_ready low.
    step(1, 32'h00100093, 64'h0, 0);
    chk("bp1 imm", 64'(imm32), 64'd1);
    chk("bp1 ready", 64'(rdy32), 64'd1);
    step(1, 32'h00200093, 64'h0, 0);
    chk("bp2 ready", 64'(rdy32), 64'd0);
    chk("bp2 imm held", 64'(imm32), 64'd1);
    step(1, 32'h00300093, 64'h0, 0);
    chk("bp3 imm held", 64'(imm32), 64'd1);
    chk("bp3 valid", 64'(vld32), 64'd1);
    step(1, 32'h00300093, 64'h0, 1);
    chk("bp rel1 imm", 64'(imm32), 64'd2);
    chk("bp rel1 ready", 64'(rdy32), 64'd1);
    step(1, 32'h00300093, 64'h0, 1);
    chk("bp rel2 imm", 64'(imm32), 64'd3);
    step(0, 32'h0, 64'h0, 1);
    chk("bp done valid", 64'(vld32), 64'd0);

    // Asynchronous reset with both entries full.
    step(1, 32'h00100093, 64'h0, 0);
    step(1, 32'h00200093, 64'h0, 0);
    chk("full ready", 64'(rdy32), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst valid32", 64'(vld32), 64'd0);
    chk("arst ready32", 64'(rdy32), 64'd1);
    chk("arst valid64", 64'(vld64), 64'd0);
    q.delete();
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    step(1, 32'h00500093, 64'h0, 0);
    chk("post rst imm", 64'(imm32), 64'd5);
    chk("post rst valid", 64'(vld32), 64'd1);
    step(0, 32'h0, 64'h0, 1);
    chk("post rst drained", 64'(vld32), 64'd0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
